// File: rtl/seq_det_pkg.sv
// Shared types, default sizes and the masked pattern compare for the
// time-multiplexed serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    DIS = 2'd0,
    CLR = 2'd1,
    RUN = 2'd2
  } ctrl_state_t;

  localparam int NCH_D     = 4;
  localparam int PAT_MAX_D = 8;
  localparam int CNT_W_D   = 8;

  // True when the low 'len' bits of hist and pat agree. Operands are
  // zero-extended to 32 bits so one function serves every PAT_MAX up to 32.
  function automatic logic pat_match(input logic [31:0] hist,
                                     input logic [31:0] pat,
                                     input logic [5:0]  len);
    logic [31:0] mask;
    if (len >= 6'd32) mask = '1;
    else              mask = (32'd1 << len) - 32'd1;
    return ((hist ^ pat) & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/seq_det_sched_rr_arbiter.sv
// Round-robin arbiter: searches req starting at ptr, wrapping modulo NCH,
// and returns the first requester as a one-hot grant plus its index.
module rr_arbiter
  import seq_det_pkg::*;
#(
  parameter int NCH = NCH_D
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] ptr,
  output logic [NCH-1:0]         grant,
  output logic [$clog2(NCH)-1:0] idx
);

  localparam int IW = $clog2(NCH);

  // Walk offsets from farthest to nearest so the channel closest to ptr
  // is the last one written and therefore wins.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    j     = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NCH;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// One programmable pattern detector shared by NCH bit streams. Each stream
// keeps its own history/fill context; a round-robin arbiter picks one stream
// per cycle. Matches are reported with the channel number and counted per
// channel with saturating counters.
//
// Handshake: a channel's bit moves only on a cycle where bit_valid[i] and
// bit_ready[i] are both high; the sender keeps bit_valid/bit_data stable
// until then, and bit_ready is at most one-hot and never depends on bit_data.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int NCH     = NCH_D,
  parameter int PAT_MAX = PAT_MAX_D,
  parameter int CNT_W   = CNT_W_D
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         cfg_we,
  input  logic [PAT_MAX-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_MAX+1)-1:0] cfg_len,
  input  logic [NCH-1:0]               bit_valid,
  input  logic [NCH-1:0]               bit_data,
  output logic [NCH-1:0]               bit_ready,
  output logic                         busy,
  output logic                         match_valid,
  output logic [$clog2(NCH)-1:0]       match_ch,
  output logic [NCH*CNT_W-1:0]         match_cnt
);

  localparam int LW = $clog2(PAT_MAX + 1);
  localparam int CW = $clog2(NCH);

  localparam logic [CW-1:0]    LAST_CH  = CW'(NCH - 1);
  localparam logic [CW-1:0]    CH_ONE   = CW'(1);
  localparam logic [LW-1:0]    FILL_MAX = LW'(PAT_MAX);
  localparam logic [LW-1:0]    FILL_ONE = LW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ctrl_state_t        state;
  logic [PAT_MAX-1:0] pat_q;
  logic [LW-1:0]      len_q;
  logic [CW-1:0]      ptr;
  logic [CW-1:0]      clr_idx;

  logic [PAT_MAX-1:0] hist [NCH];
  logic [LW-1:0]      fill [NCH];
  logic [CNT_W-1:0]   cnt  [NCH];

  logic [NCH-1:0]     grant;
  logic [CW-1:0]      gidx;
  logic               acc;
  logic               hit;
  logic               new_bit;
  logic [PAT_MAX-1:0] new_hist;
  logic [LW-1:0]      new_fill;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req   (bit_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  assign bit_ready = (state == RUN) ? grant : '0;
  assign acc       = |bit_ready;
  assign busy      = (state == CLR);

  // Next context of the granted channel and the match decision on it.
  always_comb begin
    new_bit  = bit_data[gidx];
    new_hist = {hist[gidx][PAT_MAX-2:0], new_bit};
    new_fill = (fill[gidx] == FILL_MAX) ? FILL_MAX : fill[gidx] + FILL_ONE;
    hit      = acc && (len_q != '0) && (new_fill >= len_q) &&
               pat_match(32'(new_hist), 32'(pat_q), 6'(len_q));
  end

  // Control FSM: configuration latch, clear walk and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= DIS;
      pat_q   <= '0;
      len_q   <= '0;
      ptr     <= '0;
      clr_idx <= '0;
    end else begin
      case (state)
        DIS: begin
          if (cfg_we) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
          end
          if (en) begin
            state   <= CLR;
            clr_idx <= '0;
          end
        end
        CLR: begin
          if (!en)                    state   <= DIS;
          else if (clr_idx == LAST_CH) state   <= RUN;
          else                        clr_idx <= clr_idx + CH_ONE;
        end
        RUN: begin
          if (acc) ptr <= (gidx == LAST_CH) ? '0 : gidx + CH_ONE;
          if (!en) state <= DIS;
        end
        default: state <= DIS;
      endcase
    end
  end

  // Per-channel contexts and counters: cleared by the CLR walk, advanced on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        hist[i] <= '0;
        fill[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (state == CLR && en && clr_idx == CW'(i)) begin
          hist[i] <= '0;
          fill[i] <= '0;
          cnt[i]  <= '0;
        end else if (acc && gidx == CW'(i)) begin
          hist[i] <= new_hist;
          fill[i] <= new_fill;
          if (hit && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Registered match report; match_ch keeps the last reporting channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_valid <= 1'b0;
      match_ch    <= '0;
    end else begin
      match_valid <= hit;
      if (hit) match_ch <= gidx;
    end
  end

  // Pack counters onto the flat output bus.
  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < NCH; i++) match_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// Testbench for seq_det_sched: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based reference model.
module tb_seq_det_sched;

  localparam int NCH     = 4;
  localparam int PAT_MAX = 8;
  localparam int CNT_W   = 8;
  localparam int LW      = $clog2(PAT_MAX + 1);
  localparam int CW      = $clog2(NCH);

  localparam int S_DIS = 0;
  localparam int S_CLR = 1;
  localparam int S_RUN = 2;

  logic                 clk;
  logic                 reset;
  logic                 en;
  logic                 cfg_we;
  logic [PAT_MAX-1:0]   cfg_pattern;
  logic [LW-1:0]        cfg_len;
  logic [NCH-1:0]       bit_valid;
  logic [NCH-1:0]       bit_data;
  logic [NCH-1:0]       bit_ready;
  logic                 busy;
  logic                 match_valid;
  logic [CW-1:0]        match_ch;
  logic [NCH*CNT_W-1:0] match_cnt;

  seq_det_sched #(.NCH(NCH), .PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .bit_ready   (bit_ready),
    .busy        (busy),
    .match_valid (match_valid),
    .match_ch    (match_ch),
    .match_cnt   (match_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-channel history as a queue of bits, newest at index 0.
  int m_state;
  int m_ptr;
  int m_clr;
  int m_len;
  logic [PAT_MAX-1:0] m_pat;
  bit m_hist [NCH][$];
  int m_cnt  [NCH];
  bit m_mv;
  int m_mch;

  int n_chk;
  int n_pass;
  int n_fail;
  int busy_cycles;
  int obs_grant;
  int last_grant;
  bit auto_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_DIS;
    m_ptr   = 0;
    m_clr   = 0;
    m_len   = 0;
    m_pat   = '0;
    m_mv    = 1'b0;
    m_mch   = 0;
    for (int i = 0; i < NCH; i++) begin
      m_hist[i].delete();
      m_cnt[i] = 0;
    end
  endtask

  function automatic int model_grant();
    if (reset || m_state != S_RUN) return -1;
    for (int k = 0; k < NCH; k++)
      if (bit_valid[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
    return -1;
  endfunction

  function automatic bit model_matches(int ch);
    if (m_len == 0 || m_hist[ch].size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (m_hist[ch][k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input int g);
    if (reset) begin
      model_reset();
      return;
    end
    m_mv = 1'b0;
    case (m_state)
      S_DIS: begin
        if (cfg_we) begin
          m_pat = cfg_pattern;
          m_len = int'(cfg_len);
        end
        if (en) begin
          m_state = S_CLR;
          m_clr   = 0;
        end
      end
      S_CLR: begin
        if (!en) m_state = S_DIS;
        else begin
          m_hist[m_clr].delete();
          m_cnt[m_clr] = 0;
          if (m_clr == NCH - 1) m_state = S_RUN;
          else m_clr++;
        end
      end
      default: begin
        if (g >= 0) begin
          m_hist[g].push_front(bit_data[g]);
          if (m_hist[g].size() > PAT_MAX) void'(m_hist[g].pop_back());
          if (model_matches(g)) begin
            m_mv  = 1'b1;
            m_mch = g;
            if (m_cnt[g] < (1 << CNT_W) - 1) m_cnt[g]++;
          end
          m_ptr = (g + 1) % NCH;
        end
        if (!en) m_state = S_DIS;
      end
    endcase
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic tick();
    logic [NCH-1:0]       er;
    logic [NCH*CNT_W-1:0] ec;
    int g;
    @(negedge clk);
    g  = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    ec = '0;
    for (int i = 0; i < NCH; i++) ec[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    chk("bit_ready", 64'(bit_ready), 64'(er));
    chk("busy", 64'(busy), 64'(m_state == S_CLR));
    chk("match_valid", 64'(match_valid), 64'(m_mv));
    chk("match_ch", 64'(match_ch), 64'(m_mch));
    chk("match_cnt", 64'(match_cnt), 64'(ec));
    obs_grant = -1;
    for (int i = 0; i < NCH; i++) if (bit_ready[i] === 1'b1) obs_grant = i;
    if (busy === 1'b1) busy_cycles++;
    @(posedge clk);
    model_step(g);
    last_grant = g;
    #1;
    if (auto_drop && g >= 0) bit_valid[g] = 1'b0;
  endtask

  task automatic send_bit(input int ch, input logic b);
    bit ok;
    ok = 1'b0;
    bit_valid[ch] = 1'b1;
    bit_data[ch]  = b;
    for (int t = 0; t < 16 && !ok; t++) begin
      tick();
      if (last_grant == ch) ok = 1'b1;
    end
    chk("accept_bound", 64'(ok), 64'(1));
    bit_valid[ch] = 1'b0;
  endtask

  task automatic reconfig(input logic [PAT_MAX-1:0] pat, input int len);
    en = 1'b0;
    tick();
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = LW'(len);
    tick();
    cfg_we = 1'b0;
    en     = 1'b1;
    repeat (NCH + 1) tick();
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int ch);
    return match_cnt[ch*CNT_W +: CNT_W];
  endfunction

  initial begin
    int start;
    n_chk = 0; n_pass = 0; n_fail = 0;
    busy_cycles = 0; obs_grant = -1; last_grant = -1; auto_drop = 1'b1;
    reset = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
    bit_valid = '0; bit_data = '0;
    model_reset();

    // Reset values, then release
    tick();
    reset = 1'b0;
    tick();

    // Rising-edge pattern 01 on channel 0; clear walk lasts NCH cycles
    cfg_we = 1'b1; cfg_pattern = 8'h01; cfg_len = LW'(2);
    tick();
    cfg_we = 1'b0; en = 1'b1;
    tick();
    busy_cycles = 0;
    repeat (NCH + 1) tick();
    chk("clr_cycles", 64'(busy_cycles), 64'(NCH));
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    chk("cnt0_edge", 64'(cnt_of(0)), 64'(1));
    tick();

    // All channels requesting continuously: strict rotation
    auto_drop = 1'b0;
    bit_valid = '1;
    start = m_ptr;
    for (int k = 0; k < 2 * NCH; k++) begin
      bit_data = NCH'($urandom);
      tick();
      chk("rr_seq", 64'(obs_grant), 64'((start + k) % NCH));
    end
    bit_valid = '0;
    auto_drop = 1'b1;
    tick();

    // Overlapping 101 on channel 2
    reconfig(8'b101, 3);
    send_bit(2, 1'b1);
    send_bit(2, 1'b0);
    chk("cnt2_two_bits", 64'(cnt_of(2)), 64'(0));
    send_bit(2, 1'b1);
    send_bit(2, 1'b0);
    send_bit(2, 1'b1);
    chk("cnt2_overlap", 64'(cnt_of(2)), 64'(2));
    tick();

    // Fill check: 000 must not match before three bits have arrived
    reconfig(8'b000, 3);
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    chk("cnt0_fill", 64'(cnt_of(0)), 64'(0));
    send_bit(0, 1'b0);
    chk("cnt0_fill3", 64'(cnt_of(0)), 64'(1));
    tick();

    // Saturation: 300 matches on channel 1
    reconfig(8'b1, 1);
    for (int k = 0; k < 300; k++) send_bit(1, 1'b1);
    tick();
    chk("cnt1_sat", 64'(cnt_of(1)), 64'(255));

    // Configuration write while running is ignored
    cfg_we = 1'b1; cfg_pattern = 8'h00; cfg_len = LW'(1);
    tick();
    cfg_we = 1'b0;
    send_bit(3, 1'b1);
    send_bit(3, 1'b0);
    chk("cnt3_oldpat", 64'(cnt_of(3)), 64'(1));
    tick();
    reconfig(8'h00, 1);
    chk("cnt1_cleared", 64'(cnt_of(1)), 64'(0));
    send_bit(3, 1'b0);
    send_bit(3, 1'b1);
    chk("cnt3_newpat", 64'(cnt_of(3)), 64'(1));
    tick();

    // Reset in the middle of RUN with every channel requesting
    auto_drop = 1'b0;
    bit_valid = '1;
    tick();
    tick();
    #2;
    reset = 1'b1;
    model_reset();
    tick();
    reset = 1'b0;
    bit_valid = '0;
    auto_drop = 1'b1;
    chk("rst_cnt", 64'(match_cnt), 64'(0));
    chk("rst_ready", 64'(bit_ready), 64'(0));
    tick();

    // Abort the clear walk midway, then restart it
    en = 1'b1;
    tick();
    tick();
    tick();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    busy_cycles = 0;
    repeat (NCH + 2) tick();
    chk("clr_restart", 64'(busy_cycles), 64'(NCH));

    // Random traffic with occasional reconfiguration
    reconfig(PAT_MAX'($urandom), 3);
    for (int c = 0; c < 2500; c++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (!bit_valid[ch] && $urandom_range(0, 99) < 50) begin
          bit_valid[ch] = 1'b1;
          bit_data[ch]  = 1'($urandom_range(0, 1));
        end
      end
      if ($urandom_range(0, 299) == 0)
        reconfig(PAT_MAX'($urandom), $urandom_range(0, PAT_MAX));
      else
        tick();
    end
    bit_valid = '0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
